// File: rtl/wfifo_drain_pkg.sv
// Shared types and constants for the write-FIFO burst drain.
// Holds FSM encodings, the OKAY response code and a saturating increment.
package wfifo_drain_pkg;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_ADDR = 2'd1,
    S_DATA = 2'd2,
    S_RESP = 2'd3
  } state_t;

  localparam logic [1:0] BRESP_OKAY = 2'b00;

  function automatic logic [31:0] sat_inc(input logic [31:0] v);
    return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
  endfunction

endpackage

// File: rtl/wburst_addr_gen.sv
// Burst address and remaining-burst tracker for the drain FSM.
// load captures the frame config; step retires one burst.
module wburst_addr_gen #(
  parameter int ADDR_W = 32,
  parameter int FRAME_W = 16,
  parameter logic [ADDR_W-1:0] STEP = '0
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              load,
  input  logic [ADDR_W-1:0] base,
  input  logic [FRAME_W-1:0] bursts,
  input  logic              step,
  output logic [ADDR_W-1:0] addr,
  output logic              last
);

  logic [FRAME_W-1:0] left;

  assign last = (left == FRAME_W'(1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      addr <= '0;
      left <= '0;
    end else if (load) begin
      addr <= base;
      left <= bursts;
    end else if (step) begin
      left <= left - FRAME_W'(1);
      // address wraps modulo 2^ADDR_W
      if (!last) addr <= addr + STEP;
    end
  end

endmodule

// File: rtl/wfifo_burst_drain.sv
// Drains a show-ahead FIFO into fixed-length write bursts, one outstanding.
// Optional WBURST_STAT_EN adds saturating burst/stall counters.
module wfifo_burst_drain
  import wfifo_drain_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 32,
  parameter int BURST_LEN = 16,
  parameter int FRAME_W = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [ADDR_W-1:0] cfg_base_addr,
  input  logic [FRAME_W-1:0] cfg_frame_bursts,
  input  logic [DATA_W-1:0] fifo_rd_data,
  input  logic              fifo_rd_vld,
  output logic              fifo_rd_en,
  output logic [ADDR_W-1:0] m_awaddr,
  output logic [7:0]        m_awlen,
  output logic              m_awvalid,
  input  logic              m_awready,
  output logic [DATA_W-1:0] m_wdata,
  output logic              m_wlast,
  output logic              m_wvalid,
  input  logic              m_wready,
  input  logic              m_bvalid,
  output logic              m_bready,
  input  logic [1:0]        m_bresp,
  output logic              busy,
  output logic              frame_done,
  output logic              err
`ifdef WBURST_STAT_EN
  ,
  output logic [31:0]       stat_bursts,
  output logic [31:0]       stat_stalls
`endif
);

  localparam logic [ADDR_W-1:0] STEP =
    ADDR_W'(BURST_LEN * DATA_W / 8);
  localparam logic [7:0] LAST_BEAT = 8'(BURST_LEN - 1);

  state_t state, nxt;
  logic [7:0] beat_cnt;
  logic load, step, last;
  logic accept, zero_frame, b_hs, beat;

  assign m_awlen = LAST_BEAT;
  assign busy = (state != S_IDLE);
  assign accept = (state == S_IDLE) && start;
  assign zero_frame = (cfg_frame_bursts == '0);
  assign b_hs = (state == S_RESP) && m_bvalid;
  assign beat = m_wvalid && m_wready;

  wburst_addr_gen #(
    .ADDR_W(ADDR_W),
    .FRAME_W(FRAME_W),
    .STEP(STEP)
  ) u_addr (
    .clk(clk),
    .rst_n(rst_n),
    .load(load),
    .base(cfg_base_addr),
    .bursts(cfg_frame_bursts),
    .step(step),
    .addr(m_awaddr),
    .last(last)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= S_IDLE;
    else state <= nxt;
  end

  always_comb begin
    nxt = state;
    m_awvalid = 1'b0;
    m_wvalid = 1'b0;
    m_wdata = '0;
    m_wlast = 1'b0;
    fifo_rd_en = 1'b0;
    m_bready = 1'b0;
    load = 1'b0;
    step = 1'b0;
    unique case (state)
      S_IDLE: begin
        if (start) begin
          load = 1'b1;
          if (!zero_frame) nxt = S_ADDR;
        end
      end
      S_ADDR: begin
        m_awvalid = 1'b1;
        if (m_awready) nxt = S_DATA;
      end
      S_DATA: begin
        m_wvalid = fifo_rd_vld;
        m_wdata = fifo_rd_data;
        m_wlast = (beat_cnt == LAST_BEAT);
        fifo_rd_en = m_wready && fifo_rd_vld;
        if (fifo_rd_en && m_wlast) nxt = S_RESP;
      end
      S_RESP: begin
        m_bready = 1'b1;
        if (m_bvalid) begin
          step = 1'b1;
          nxt = last ? S_IDLE : S_ADDR;
        end
      end
      default: nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      beat_cnt <= '0;
      err <= 1'b0;
      frame_done <= 1'b0;
    end else begin
      frame_done <= (accept && zero_frame) || (b_hs && last);
      if (state == S_ADDR) beat_cnt <= '0;
      else if (beat) beat_cnt <= beat_cnt + 8'd1;
      if (accept) err <= 1'b0;
      else if (b_hs && m_bresp != BRESP_OKAY) err <= 1'b1;
    end
  end

`ifdef WBURST_STAT_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stat_bursts <= '0;
      stat_stalls <= '0;
    end else if (accept) begin
      stat_bursts <= '0;
      stat_stalls <= '0;
    end else begin
      if (b_hs) stat_bursts <= sat_inc(stat_bursts);
      if (state == S_DATA && !(fifo_rd_vld && m_wready))
        stat_stalls <= sat_inc(stat_stalls);
    end
  end
`endif

endmodule
